// File: rtl/lift_multi_floor_ctrl_pkg.sv
// Shared definitions for the multi-floor lift controller: FSM state encodings,
// travel-direction constants and a small state-class helper.
package lift_multi_floor_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        DOOR_OPEN  = 4'd1,
        DOOR_CLOSE = 4'd2,
        START_UP   = 4'd3,
        MOVE_UP    = 4'd4,
        START_DOWN = 4'd5,
        MOVE_DOWN  = 4'd6,
        EMERGENCY  = 4'd7,
        MAINT      = 4'd8
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic is_motoring(state_t s);
        return s inside {START_UP, MOVE_UP, START_DOWN, MOVE_DOWN};
    endfunction

endpackage

// File: rtl/lift_call_queue.sv
// Pending-call register for the lift controller: latches call requests, clears
// served floors and reports whether calls lie above, below or at the car.
module lift_call_queue #(
    parameter int  NUM_FLOORS = 8,
    localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  block_here,
    input  logic                  clear_en,
    input  logic [FLOOR_W-1:0]    clear_floor,
    input  logic                  clear_all,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  hit_here
);

    logic [NUM_FLOORS-1:0] pending_next;
    logic [NUM_FLOORS-1:0] set_bits;
    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        set_bits = call_req;
        if (block_here) set_bits[cur_floor] = 1'b0;
        pending_next = pending | set_bits;
        if (clear_en)  pending_next[clear_floor] = 1'b0;
        if (clear_all) pending_next = '0;
    end

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_mask[i] = (i > int'(cur_floor));
            below_mask[i] = (i < int'(cur_floor));
        end
    end

    assign any_above = |(pending & above_mask);
    assign any_below = |(pending & below_mask);
    assign hit_here  = pending[cur_floor];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= pending_next;
    end

endmodule

// File: rtl/lift_multi_floor_ctrl.sv
// N-floor SCAN lift controller: FSM, door and travel timers, floor counter and
// sticky travel fault, with emergency and maintenance overrides.
module lift_multi_floor_ctrl
    import lift_multi_floor_ctrl_pkg::*;
#(
    parameter int  NUM_FLOORS     = 8,
    parameter int  DOOR_CYCLES    = 16,
    parameter int  TRAVEL_TIMEOUT = 64,
    localparam int FLOOR_W        = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  doors_closed,
    input  logic                  floor_tick,
    input  logic                  emergency,
    input  logic                  maintenance,
    output logic [3:0]            state,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  motor_on,
    output logic                  motor_direction,
    output logic                  door_open,
    output logic                  fan_on,
    output logic                  fault
);

    localparam int DT_W = $clog2(DOOR_CYCLES + 1);
    localparam int TT_W = $clog2(TRAVEL_TIMEOUT + 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [DT_W-1:0]    DOOR_LAST  = DT_W'(DOOR_CYCLES - 1);
    localparam logic [TT_W-1:0]    TRAVEL_MAX = TT_W'(TRAVEL_TIMEOUT - 1);

    state_t             st, nxt, decide;
    logic [FLOOR_W-1:0] next_floor, up_floor, dn_floor;
    logic [DT_W-1:0]    door_timer;
    logic [TT_W-1:0]    travel_timer;
    logic               pref_dir, fault_set, fault_clr, door_rearm;
    logic               any_above, any_below, hit_here;

    lift_call_queue #(.NUM_FLOORS(NUM_FLOORS)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .call_req    (call_req),
        .cur_floor   (cur_floor),
        .block_here  (st == DOOR_OPEN),
        .clear_en    (nxt == DOOR_OPEN && st != DOOR_OPEN),
        .clear_floor (next_floor),
        .clear_all   (nxt == MAINT),
        .pending     (pending),
        .any_above   (any_above),
        .any_below   (any_below),
        .hit_here    (hit_here)
    );

    assign up_floor = cur_floor + FLOOR_W'(1);
    assign dn_floor = cur_floor - FLOOR_W'(1);

    // SCAN choice: serve here, else keep the last direction, else reverse.
    always_comb begin
        decide = IDLE;
        if (hit_here) begin
            decide = DOOR_OPEN;
        end else if (pref_dir == DIR_UP) begin
            if (any_above)      decide = START_UP;
            else if (any_below) decide = START_DOWN;
        end else begin
            if (any_below)      decide = START_DOWN;
            else if (any_above) decide = START_UP;
        end
    end

    always_comb begin
        nxt        = st;
        next_floor = cur_floor;
        fault_set  = 1'b0;
        door_rearm = 1'b0;
        case (st)
            IDLE:       nxt = decide;
            DOOR_OPEN: begin
                if (call_req[cur_floor])       door_rearm = 1'b1;
                else if (door_timer == DOOR_LAST) nxt = DOOR_CLOSE;
            end
            DOOR_CLOSE: if (doors_closed) nxt = decide;
            START_UP:   nxt = doors_closed ? MOVE_UP : DOOR_CLOSE;
            START_DOWN: nxt = doors_closed ? MOVE_DOWN : DOOR_CLOSE;
            MOVE_UP: begin
                if (!doors_closed) begin
                    nxt = EMERGENCY;
                end else if (floor_tick) begin
                    if (cur_floor == TOP_FLOOR) begin
                        fault_set = 1'b1;
                        nxt       = EMERGENCY;
                    end else begin
                        next_floor = up_floor;
                        if (pending[up_floor])        nxt = DOOR_OPEN;
                        else if (up_floor == TOP_FLOOR) nxt = IDLE;
                    end
                end else if (travel_timer == TRAVEL_MAX) begin
                    fault_set = 1'b1;
                    nxt       = EMERGENCY;
                end
            end
            MOVE_DOWN: begin
                if (!doors_closed) begin
                    nxt = EMERGENCY;
                end else if (floor_tick) begin
                    if (cur_floor == '0) begin
                        fault_set = 1'b1;
                        nxt       = EMERGENCY;
                    end else begin
                        next_floor = dn_floor;
                        if (pending[dn_floor])  nxt = DOOR_OPEN;
                        else if (dn_floor == '0) nxt = IDLE;
                    end
                end else if (travel_timer == TRAVEL_MAX) begin
                    fault_set = 1'b1;
                    nxt       = EMERGENCY;
                end
            end
            EMERGENCY:  if (!emergency && !fault) nxt = IDLE;
            MAINT:      if (!maintenance) nxt = IDLE;
            default:    nxt = IDLE;
        endcase

        if (maintenance && st inside {IDLE, DOOR_OPEN, DOOR_CLOSE}) nxt = MAINT;
        if (emergency) begin
            nxt        = EMERGENCY;
            next_floor = cur_floor;
            fault_set  = 1'b0;
        end
    end

    assign fault_clr = maintenance && !emergency && !is_motoring(st);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st              <= IDLE;
            cur_floor       <= '0;
            motor_direction <= DIR_DN;
            pref_dir        <= DIR_UP;
            fault           <= 1'b0;
            door_timer      <= '0;
            travel_timer    <= '0;
        end else begin
            st        <= nxt;
            cur_floor <= next_floor;
            if (nxt == START_UP) begin
                motor_direction <= DIR_UP;
                pref_dir        <= DIR_UP;
            end else if (nxt == START_DOWN) begin
                motor_direction <= DIR_DN;
                pref_dir        <= DIR_DN;
            end
            if (fault_set)      fault <= 1'b1;
            else if (fault_clr) fault <= 1'b0;
            door_timer   <= (st == DOOR_OPEN && nxt == DOOR_OPEN && !door_rearm)
                            ? door_timer + DT_W'(1) : '0;
            travel_timer <= ((st == MOVE_UP || st == MOVE_DOWN) && nxt == st && !floor_tick)
                            ? travel_timer + TT_W'(1) : '0;
        end
    end

    assign state     = st;
    assign motor_on  = is_motoring(st);
    assign door_open = (st == DOOR_OPEN);
    assign fan_on    = motor_on || (st == EMERGENCY);

endmodule

// File: tb/tb_lift_multi_floor_ctrl.sv
// Directed bench for lift_multi_floor_ctrl (8 floors, 4-clock door, 20-clock travel timeout):
// a cycle-by-cycle vector table followed by hand-written multi-cycle sequences.
module tb_lift_multi_floor_ctrl;
    import lift_multi_floor_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] call_req = '0;
    logic       doors_closed = 1'b1;
    logic       floor_tick = 1'b0;
    logic       emergency = 1'b0;
    logic       maintenance = 1'b0;
    logic [3:0] state;
    logic [2:0] cur_floor;
    logic [7:0] pending;
    logic       motor_on, motor_direction, door_open, fan_on, fault;

    int n_checks = 0;
    int n_fail   = 0;

    lift_multi_floor_ctrl #(.NUM_FLOORS(8), .DOOR_CYCLES(4), .TRAVEL_TIMEOUT(20)) dut (
        .clk             (clk),
        .reset           (reset),
        .call_req        (call_req),
        .doors_closed    (doors_closed),
        .floor_tick      (floor_tick),
        .emergency       (emergency),
        .maintenance     (maintenance),
        .state           (state),
        .cur_floor       (cur_floor),
        .pending         (pending),
        .motor_on        (motor_on),
        .motor_direction (motor_direction),
        .door_open       (door_open),
        .fan_on          (fan_on),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] call;
        logic       dc, tick, emg, mnt;
        logic [3:0] st;
        logic [2:0] flr;
        logic [7:0] pend;
        logic       mot, dir, door, fan, flt;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        floor_tick = 1'b1;
        cycle();
        floor_tick = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int budget, input string name);
        int n = 0;
        while (state !== s && n < budget) begin
            cycle();
            n++;
        end
        check(name, state, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //           call  dc tk em mn  state       flr   pend   mo di do fa ft
        vecs[0]  = '{8'h08, 1, 0, 0, 0, IDLE,       3'd0, 8'h08, 0, 0, 0, 0, 0};
        vecs[1]  = '{8'h00, 1, 0, 0, 0, START_UP,   3'd0, 8'h08, 1, 1, 0, 1, 0};
        vecs[2]  = '{8'h00, 1, 0, 0, 0, MOVE_UP,    3'd0, 8'h08, 1, 1, 0, 1, 0};
        vecs[3]  = '{8'h00, 1, 1, 0, 0, MOVE_UP,    3'd1, 8'h08, 1, 1, 0, 1, 0};
        vecs[4]  = '{8'h00, 1, 0, 0, 0, MOVE_UP,    3'd1, 8'h08, 1, 1, 0, 1, 0};
        vecs[5]  = '{8'h00, 1, 1, 0, 0, MOVE_UP,    3'd2, 8'h08, 1, 1, 0, 1, 0};
        vecs[6]  = '{8'h00, 1, 1, 0, 0, DOOR_OPEN,  3'd3, 8'h00, 0, 1, 1, 0, 0};
        vecs[7]  = '{8'h00, 0, 0, 0, 0, DOOR_OPEN,  3'd3, 8'h00, 0, 1, 1, 0, 0};
        vecs[8]  = '{8'h00, 0, 0, 0, 0, DOOR_OPEN,  3'd3, 8'h00, 0, 1, 1, 0, 0};
        vecs[9]  = '{8'h00, 0, 0, 0, 0, DOOR_OPEN,  3'd3, 8'h00, 0, 1, 1, 0, 0};
        vecs[10] = '{8'h00, 0, 0, 0, 0, DOOR_CLOSE, 3'd3, 8'h00, 0, 1, 0, 0, 0};
        vecs[11] = '{8'h00, 0, 0, 0, 0, DOOR_CLOSE, 3'd3, 8'h00, 0, 1, 0, 0, 0};
        vecs[12] = '{8'h00, 1, 0, 0, 0, IDLE,       3'd3, 8'h00, 0, 1, 0, 0, 0};
        vecs[13] = '{8'h01, 1, 0, 0, 1, MAINT,      3'd3, 8'h00, 0, 1, 0, 0, 0};
        vecs[14] = '{8'h80, 1, 0, 0, 1, MAINT,      3'd3, 8'h00, 0, 1, 0, 0, 0};
        vecs[15] = '{8'h00, 1, 0, 0, 0, IDLE,       3'd3, 8'h00, 0, 1, 0, 0, 0};
        vecs[16] = '{8'h00, 1, 0, 1, 1, EMERGENCY,  3'd3, 8'h00, 0, 1, 0, 1, 0};
        vecs[17] = '{8'h00, 1, 0, 0, 0, IDLE,       3'd3, 8'h00, 0, 1, 0, 0, 0};
        vecs[18] = '{8'h00, 1, 1, 0, 0, IDLE,       3'd3, 8'h00, 0, 1, 0, 0, 0};

        // Reset state
        cycle();
        check("reset_state", state, IDLE);
        check("reset_floor", cur_floor, 3'd0);
        check("reset_outputs", {pending, motor_on, motor_direction, door_open, fan_on, fault}, 13'd0);
        reset = 1'b1;

        // Single trip to floor 3, door timing, maintenance and emergency priority
        for (int i = 0; i < 19; i++) begin
            call_req     = vecs[i].call;
            doors_closed = vecs[i].dc;
            floor_tick   = vecs[i].tick;
            emergency    = vecs[i].emg;
            maintenance  = vecs[i].mnt;
            cycle();
            check($sformatf("v%0d_state", i), state, vecs[i].st);
            check($sformatf("v%0d_floor", i), cur_floor, vecs[i].flr);
            check($sformatf("v%0d_pending", i), pending, vecs[i].pend);
            check($sformatf("v%0d_outs", i), {motor_on, motor_direction, door_open, fan_on, fault},
                  {vecs[i].mot, vecs[i].dir, vecs[i].door, vecs[i].fan, vecs[i].flt});
        end
        call_req = '0; doors_closed = 1'b1; floor_tick = 1'b0; emergency = 1'b0; maintenance = 1'b0;

        // SCAN: from floor 3 going up, calls at 6 and 1 -> 6 first, then reverse to 1
        call_req = 8'h42;
        cycle();
        call_req = '0;
        check("scan_pending", pending, 8'h42);
        cycle();
        check("scan_start_up", state, START_UP);
        cycle();
        repeat (3) tick();
        check("scan_stop6_state", state, DOOR_OPEN);
        check("scan_stop6_floor", cur_floor, 3'd6);
        check("scan_stop6_pending", pending, 8'h02);
        wait_state(DOOR_CLOSE, 10, "scan_door_close");
        cycle();
        check("scan_reverse", state, START_DOWN);
        check("scan_reverse_dir", motor_direction, 1'b0);
        cycle();
        repeat (5) tick();
        check("scan_stop1_state", state, DOOR_OPEN);
        check("scan_stop1_floor", cur_floor, 3'd1);
        check("scan_stop1_pending", pending, 8'h00);
        wait_state(IDLE, 20, "scan_idle");

        // Travel timeout: preferred direction is down, only call is above
        call_req = 8'h10;
        cycle();
        call_req = '0;
        cycle();
        check("tmo_start_up", state, START_UP);
        cycle();
        repeat (19) cycle();
        check("tmo_still_moving", state, MOVE_UP);
        cycle();
        check("tmo_state", state, EMERGENCY);
        check("tmo_flags", {fault, fan_on, motor_on}, 3'b110);
        check("tmo_pending", pending, 8'h10);
        cycle();
        check("tmo_held", state, EMERGENCY);
        maintenance = 1'b1;
        cycle();
        check("maint_fault_clr", fault, 1'b0);
        cycle();
        check("maint_exit_emg", state, IDLE);
        cycle();
        check("maint_enter", state, MAINT);
        check("maint_pending", pending, 8'h00);
        maintenance = 1'b0;
        cycle();
        check("maint_exit", state, IDLE);

        // Emergency mid MOVE_DOWN, trip resumes afterwards
        call_req = 8'h01;
        cycle();
        call_req = '0;
        cycle();
        check("emg_start_down", state, START_DOWN);
        cycle();
        cycle();
        emergency = 1'b1;
        cycle();
        check("emg_state", state, EMERGENCY);
        check("emg_motor", {motor_on, fan_on}, 2'b01);
        check("emg_pending", pending, 8'h01);
        cycle();
        emergency = 1'b0;
        cycle();
        check("emg_exit", state, IDLE);
        cycle();
        cycle();
        check("emg_resume", state, MOVE_DOWN);
        tick();
        check("emg_arrive_state", state, DOOR_OPEN);
        check("emg_arrive_floor", cur_floor, 3'd0);
        wait_state(IDLE, 20, "emg_idle");

        // Door opened while moving, then reset mid-travel
        call_req = 8'h04;
        cycle();
        call_req = '0;
        cycle();
        cycle();
        check("door_move", state, MOVE_UP);
        doors_closed = 1'b0;
        cycle();
        check("door_emg", state, EMERGENCY);
        check("door_no_fault", fault, 1'b0);
        doors_closed = 1'b1;
        cycle();
        check("door_recover", state, IDLE);
        cycle();
        cycle();
        tick();
        check("rst_mid_floor", cur_floor, 3'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_state", state, IDLE);
        check("rst_mid_outs", {cur_floor, pending, motor_on, motor_direction, door_open, fan_on, fault}, 16'd0);
        cycle();
        reset = 1'b1;
        cycle();

        // Call at the current floor while the door is open re-arms the timer
        call_req = 8'h01;
        cycle();
        call_req = '0;
        cycle();
        check("rearm_open", state, DOOR_OPEN);
        cycle();
        cycle();
        call_req = 8'h01;
        cycle();
        call_req = '0;
        check("rearm_pending", pending, 8'h00);
        repeat (3) cycle();
        check("rearm_still_open", state, DOOR_OPEN);
        cycle();
        check("rearm_close", state, DOOR_CLOSE);
        cycle();
        check("rearm_idle", state, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
